// File: rtl/sys_defs.sv
// Shared definitions for the rename map table and its read ports.
package sys_defs;

  localparam int NUM_ARCH_REGS = 32;
  localparam int ROB_SIZE      = 8;
  localparam int TAG_W         = $clog2(ROB_SIZE + 1);
  localparam int IDX_W         = $clog2(NUM_ARCH_REGS);

  // Tag 0 means "value lives in the register file"; 1..ROB_SIZE name ROB entries.
  typedef logic [TAG_W-1:0] ROB_TAG;
  typedef logic [IDX_W-1:0] ARCH_IDX;

  // Operand information handed to the reservation station at dispatch.
  typedef struct packed {
    ROB_TAG rs1_tag;
    ROB_TAG rs2_tag;
    logic   rs1_ready;
    logic   rs2_ready;
  } MT2RS_PACKET;

  // One completing ROB entry on the common data bus.
  typedef struct packed {
    logic   valid;
    ROB_TAG tag;
  } CDB_PACKET;

endpackage

// File: rtl/mt_read_port.sv
// One source-operand lookup into the map table, with same-cycle CDB bypass.
module mt_read_port
  import sys_defs::*;
(
  input  ARCH_IDX                    idx,
  input  ROB_TAG [NUM_ARCH_REGS-1:0] tags,
  input  logic   [NUM_ARCH_REGS-1:0] ready,
  input  CDB_PACKET                  cdb,
  output ROB_TAG                     tag_out,
  output logic                       ready_out
);

  ROB_TAG cur_tag;
  logic   cur_ready;
  logic   bypass_hit;

  // Register 0 always reads as "from regfile, not ready"; a broadcast of the
  // mapped tag marks the operand ready this same cycle.
  always_comb begin
    cur_tag    = '0;
    cur_ready  = 1'b0;
    bypass_hit = 1'b0;
    if (idx != '0) begin
      cur_tag   = tags[idx];
      cur_ready = ready[idx];
    end
    bypass_hit = cdb.valid && (cdb.tag == cur_tag) && (cur_tag != '0);
    tag_out    = cur_tag;
    ready_out  = cur_ready | bypass_hit;
  end

endmodule

// File: rtl/map_table.sv
// Register-rename map table: per-register producing ROB tag and completion bit.
module map_table
  import sys_defs::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        dispatch_en,
  input  ARCH_IDX     rs1_idx,
  input  ARCH_IDX     rs2_idx,
  input  ARCH_IDX     dest_reg_idx,
  input  ROB_TAG      dispatch_tag,
  input  logic        cdb_valid,
  input  ROB_TAG      cdb_tag,
  input  logic        retire_en,
  input  ARCH_IDX     retire_reg_idx,
  input  ROB_TAG      retire_tag,
  input  logic        squash,
  output MT2RS_PACKET mt2rs_packet_out
);

  ROB_TAG [NUM_ARCH_REGS-1:0] tags;
  logic   [NUM_ARCH_REGS-1:0] ready;
  CDB_PACKET                  cdb;

  ROB_TAG rs1_tag;
  ROB_TAG rs2_tag;
  logic   rs1_ready;
  logic   rs2_ready;

  // Bundle the broadcast so both read ports see the same view of it.
  always_comb begin
    cdb.valid = cdb_valid;
    cdb.tag   = cdb_tag;
  end

  // Lookups use pre-update state, so a self-dependent instruction sees the old mapping.
  mt_read_port u_rs1 (
    .idx       (rs1_idx),
    .tags      (tags),
    .ready     (ready),
    .cdb       (cdb),
    .tag_out   (rs1_tag),
    .ready_out (rs1_ready)
  );

  mt_read_port u_rs2 (
    .idx       (rs2_idx),
    .tags      (tags),
    .ready     (ready),
    .cdb       (cdb),
    .tag_out   (rs2_tag),
    .ready_out (rs2_ready)
  );

  // Pack the two lookups for the reservation station.
  always_comb begin
    mt2rs_packet_out.rs1_tag   = rs1_tag;
    mt2rs_packet_out.rs2_tag   = rs2_tag;
    mt2rs_packet_out.rs1_ready = rs1_ready;
    mt2rs_packet_out.rs2_ready = rs2_ready;
  end

  // Per-register update, priority squash > dispatch > retire > CDB; entry 0 is never written.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tags  <= '0;
      ready <= '0;
    end else if (squash) begin
      tags  <= '0;
      ready <= '0;
    end else begin
      for (int r = 1; r < NUM_ARCH_REGS; r++) begin
        if (dispatch_en && (dest_reg_idx == ARCH_IDX'(r))) begin
          tags[r]  <= dispatch_tag;
          ready[r] <= 1'b0;
        end else if (retire_en && (retire_reg_idx == ARCH_IDX'(r)) &&
                     (tags[r] == retire_tag)) begin
          tags[r]  <= '0;
          ready[r] <= 1'b0;
        end else if (cdb_valid && (cdb_tag != '0) && (tags[r] == cdb_tag)) begin
          ready[r] <= 1'b1;
        end
      end
    end
  end

  // A dispatching instruction must always carry a real ROB entry.
  dispatch_tag_nonzero: assert property (
    @(posedge clock) disable iff (!reset) dispatch_en |-> (dispatch_tag != '0)
  );

endmodule
